// File: rtl/sd_cmd_spi.sv
// rtl/sd_cmd_spi.sv - SD SPI-mode command engine: frame build with CRC7, mode-0 shift, R1/OCR poll
// Chip-select belongs to the caller; only SCLK/MOSI are driven and MISO sampled.
module sd_cmd_spi #(
    parameter int SLOW_DIV = 100,
    parameter int FAST_DIV = 2,
    parameter int NCR_MAX  = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_send_cmd,
    input  logic [2:0]  i_cmd_select,
    input  logic [31:0] i_cmd_arg,
    input  logic        i_fast,
    output logic        o_confirm_pin,
    output logic [7:0]  o_response_status,
    output logic [31:0] o_ocr,
    output logic        o_busy,
    output logic        o_sclk,
    output logic        o_mosi,
    input  logic        i_miso
);

    localparam int MAXDIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int DW     = $clog2(MAXDIV) + 1;
    localparam int BW     = $clog2(NCR_MAX) + 1;
    localparam logic [DW-1:0] SLOW_M1 = DW'(SLOW_DIV - 1);
    localparam logic [DW-1:0] FAST_M1 = DW'(FAST_DIV - 1);
    localparam logic [BW-1:0] NCR_M1  = BW'(NCR_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRC,
        S_SEND,
        S_RESP,
        S_OCR,
        S_DECODE,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [39:0]   hdr_q;
    logic [6:0]    crc_q;
    logic          is_cmd58_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_cnt_q;
    logic [5:0]    bit_cnt_q;
    logic [BW-1:0] byte_cnt_q;
    logic [31:0]   rx_q;
    logic [7:0]    r1_q;
    logic          confirm_q;
    logic [7:0]    status_q;
    logic [31:0]   ocr_q;
    logic          busy_q;
    logic          sclk_q;
    logic          mosi_q;

    logic [6:0]    crc_d;
    logic [47:0]   frame_w;
    logic          tick_w;

    function automatic logic [5:0] cmd_index(input logic [2:0] sel);
        case (sel)
            3'd1:    return 6'd0;
            3'd2:    return 6'd16;
            3'd3:    return 6'd17;
            3'd4:    return 6'd24;
            3'd5:    return 6'd55;
            3'd6:    return 6'd58;
            3'd7:    return 6'd41;
            default: return 6'd0;
        endcase
    endfunction

    // bit7 set means no valid R1 arrived (timeout marker)
    function automatic logic [7:0] r1_status(input logic [7:0] r1);
        logic [7:0] s;
        if (r1[7])      s = 8'd0;
        else if (r1[6]) s = 8'd3;
        else if (r1[5]) s = 8'd4;
        else if (r1[4]) s = 8'd5;
        else if (r1[3]) s = 8'd6;
        else if (r1[2]) s = 8'd7;
        else if (r1[1]) s = 8'd8;
        else if (r1[0]) s = 8'd2;
        else            s = 8'd1;
        return s;
    endfunction

    always_comb begin
        crc_d   = {crc_q[5:0], 1'b0} ^ ({7{hdr_q[6'd39 - bit_cnt_q] ^ crc_q[6]}} & 7'h09);
        frame_w = {hdr_q, crc_q, 1'b1};
        tick_w  = (div_cnt_q == div_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            hdr_q      <= '0;
            crc_q      <= '0;
            is_cmd58_q <= 1'b0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_q       <= '0;
            r1_q       <= '0;
            confirm_q  <= 1'b0;
            status_q   <= '0;
            ocr_q      <= '0;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
        end else begin
            confirm_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b1;
                    if (i_send_cmd && (i_cmd_select != 3'd0)) begin
                        hdr_q      <= {2'b01, cmd_index(i_cmd_select), i_cmd_arg};
                        is_cmd58_q <= (i_cmd_select == 3'd6);
                        div_q      <= i_fast ? FAST_M1 : SLOW_M1;
                        crc_q      <= '0;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CRC;
                    end
                end

                S_CRC: begin
                    crc_q <= crc_d;
                    if (bit_cnt_q == 6'd39) begin
                        bit_cnt_q <= '0;
                        div_cnt_q <= '0;
                        mosi_q    <= hdr_q[39];
                        state_q   <= S_SEND;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                    end
                end

                S_SEND, S_RESP, S_OCR: begin
                    if (!tick_w) begin
                        div_cnt_q <= div_cnt_q + DW'(1);
                    end else begin
                        div_cnt_q <= '0;
                        sclk_q    <= ~sclk_q;
                        if (!sclk_q) begin
                            rx_q <= {rx_q[30:0], i_miso};
                        end else begin
                            // falling edge: advance MOSI / close out a byte
                            case (state_q)
                                S_SEND: begin
                                    if (bit_cnt_q == 6'd47) begin
                                        bit_cnt_q  <= '0;
                                        byte_cnt_q <= '0;
                                        mosi_q     <= 1'b1;
                                        confirm_q  <= 1'b1;
                                        state_q    <= S_RESP;
                                    end else begin
                                        bit_cnt_q <= bit_cnt_q + 6'd1;
                                        mosi_q    <= frame_w[6'd46 - bit_cnt_q];
                                    end
                                end
                                S_RESP: begin
                                    if (bit_cnt_q == 6'd7) begin
                                        bit_cnt_q <= '0;
                                        if (!rx_q[7]) begin
                                            r1_q    <= rx_q[7:0];
                                            state_q <= is_cmd58_q ? S_OCR : S_DECODE;
                                        end else if (byte_cnt_q == NCR_M1) begin
                                            r1_q    <= 8'hFF;
                                            state_q <= S_DECODE;
                                        end else begin
                                            byte_cnt_q <= byte_cnt_q + BW'(1);
                                        end
                                    end else begin
                                        bit_cnt_q <= bit_cnt_q + 6'd1;
                                    end
                                end
                                default: begin
                                    if (bit_cnt_q == 6'd31) begin
                                        bit_cnt_q <= '0;
                                        ocr_q     <= rx_q;
                                        state_q   <= S_DECODE;
                                    end else begin
                                        bit_cnt_q <= bit_cnt_q + 6'd1;
                                    end
                                end
                            endcase
                        end
                    end
                end

                S_DECODE: begin
                    status_q <= r1_status(r1_q);
                    state_q  <= S_DONE;
                end

                S_DONE: begin
                    confirm_q <= 1'b1;
                    busy_q    <= 1'b0;
                    sclk_q    <= 1'b0;
                    mosi_q    <= 1'b1;
                    state_q   <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_confirm_pin     = confirm_q;
    assign o_response_status = status_q;
    assign o_ocr             = ocr_q;
    assign o_busy            = busy_q;
    assign o_sclk            = sclk_q;
    assign o_mosi            = mosi_q;

endmodule
